// File: rtl/peak_detect_nch_if.sv
// Bundle of the burst-input, result-output and status signals of peak_detect_nch.
// Combinational only, so it adds no latency.
// Backpressure: res_ready from the consumer holds the result until a handshake completes.
interface peak_detect_nch_if #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int IW  = 12
);
    logic                in_valid;
    logic [NCH*DW-1:0]   din;
    logic                res_ready;
    logic                res_valid;
    logic [NCH*DW-1:0]   peak;
    logic [NCH*IW-1:0]   peak_idx;
    logic [NCH-1:0]      ovf;
    logic                trunc;
    logic                busy;

    // Producer/consumer side: drives the samples and the result acceptance
    modport master (
        output in_valid, din, res_ready,
        input  res_valid, peak, peak_idx, ovf, trunc, busy
    );

    // Detector side
    modport slave (
        input  in_valid, din, res_ready,
        output res_valid, peak, peak_idx, ovf, trunc, busy
    );
endinterface

// File: rtl/peak_detect_nch.sv
// Per-channel burst peak detector: tracks the maximum (optionally absolute) sample and its beat index.
// Latency: the result is valid on the cycle after in_valid first falls at the end of a burst.
// Backpressure: the result is held until res_ready; bursts seen while holding or re-arming are dropped.
module peak_detect_nch #(
    parameter int          NCH      = 4,
    parameter int          DW       = 16,
    parameter int          IW       = 12,
    parameter int unsigned TH       = 30000,
    parameter bit          ABS_MODE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    peak_detect_nch_if.slave bus
);

    typedef enum logic [1:0] {
        REARM = 2'd0,
        IDLE  = 2'd1,
        ACQ   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [IW-1:0] CNT_MAX  = {IW{1'b1}};
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};
    // A threshold that does not fit in DW bits can never be exceeded
    localparam bit            TH_BIG   = (DW < 32) && (64'(TH) >= (64'd1 << DW));
    localparam logic [DW-1:0] TH_V     = DW'(TH);

    state_t          state;
    logic [IW-1:0]   cnt;
    logic            cnt_full;
    logic            run_trunc;
    logic [DW-1:0]   run_peak [NCH];
    logic [IW-1:0]   run_idx  [NCH];
    logic [DW-1:0]   cand     [NCH];
    logic [DW-1:0]   smp;

    logic                res_valid_q;
    logic [NCH*DW-1:0]   peak_q;
    logic [NCH*IW-1:0]   peak_idx_q;
    logic [NCH-1:0]      ovf_q;
    logic                trunc_q;
    logic                busy_q;

    // Candidate magnitude per channel: negatives clamp to 0, or fold to |x| with saturation
    always_comb begin
        smp = '0;
        for (int i = 0; i < NCH; i++) begin
            smp     = bus.din[i*DW +: DW];
            cand[i] = '0;
            if (!smp[DW-1]) begin
                cand[i] = smp;
            end else if (ABS_MODE) begin
                cand[i] = (smp == MOST_NEG) ? MAX_POS : (~smp + 1'b1);
            end
        end
    end

    // Control FSM, running peaks and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REARM;
            cnt         <= '0;
            cnt_full    <= 1'b0;
            run_trunc   <= 1'b0;
            res_valid_q <= 1'b0;
            peak_q      <= '0;
            peak_idx_q  <= '0;
            ovf_q       <= '0;
            trunc_q     <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                run_peak[i] <= '0;
                run_idx[i]  <= '0;
            end
        end else begin
            case (state)
                // Wait for any burst in flight to end so only whole bursts are captured
                REARM: begin
                    if (!bus.in_valid) begin
                        state <= IDLE;
                    end
                end
                // First beat of a burst seeds the running peaks as beat 0
                IDLE: begin
                    if (bus.in_valid) begin
                        state     <= ACQ;
                        busy_q    <= 1'b1;
                        cnt       <= IW'(1);
                        cnt_full  <= 1'b0;
                        run_trunc <= 1'b0;
                        for (int i = 0; i < NCH; i++) begin
                            run_peak[i] <= cand[i];
                            run_idx[i]  <= '0;
                        end
                    end
                end
                ACQ: begin
                    if (bus.in_valid) begin
                        // Strictly-greater update keeps the earliest index on ties
                        for (int i = 0; i < NCH; i++) begin
                            if (cand[i] > run_peak[i]) begin
                                run_peak[i] <= cand[i];
                                run_idx[i]  <= cnt;
                            end
                        end
                        // cnt_full marks that index CNT_MAX has already been used
                        if (cnt_full) begin
                            run_trunc <= 1'b1;
                        end
                        if (cnt == CNT_MAX) begin
                            cnt_full <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state       <= HOLD;
                        res_valid_q <= 1'b1;
                        trunc_q     <= run_trunc;
                        for (int i = 0; i < NCH; i++) begin
                            peak_q[i*DW +: DW]     <= run_peak[i];
                            peak_idx_q[i*IW +: IW] <= run_idx[i];
                            ovf_q[i]               <= !TH_BIG && (run_peak[i] > TH_V);
                        end
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= REARM;
                    end
                end
                default: begin
                    state <= REARM;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.peak      = peak_q;
    assign bus.peak_idx  = peak_idx_q;
    assign bus.ovf       = ovf_q;
    assign bus.trunc     = trunc_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_peak_detect_nch.sv
// Directed bench for peak_detect_nch: three instances share one stimulus stream.
// dut0: ABS_MODE=0 IW=12, dut1: ABS_MODE=1 IW=12, dut2: ABS_MODE=0 IW=3.
// Results are accepted explicitly via res_ready between bursts.
module tb_peak_detect_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] din = '0;
    logic        res_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peak_detect_nch_if #(.NCH(4), .DW(16), .IW(12)) if0 ();
    peak_detect_nch_if #(.NCH(4), .DW(16), .IW(12)) if1 ();
    peak_detect_nch_if #(.NCH(4), .DW(16), .IW(3))  if2 ();

    assign if0.in_valid = in_valid;  assign if0.din = din;  assign if0.res_ready = res_ready;
    assign if1.in_valid = in_valid;  assign if1.din = din;  assign if1.res_ready = res_ready;
    assign if2.in_valid = in_valid;  assign if2.din = din;  assign if2.res_ready = res_ready;

    peak_detect_nch #(.NCH(4), .DW(16), .IW(12), .TH(30000), .ABS_MODE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    peak_detect_nch #(.NCH(4), .DW(16), .IW(12), .TH(30000), .ABS_MODE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    peak_detect_nch #(.NCH(4), .DW(16), .IW(3),  .TH(30000), .ABS_MODE(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] c3);
        in_valid = 1'b1;
        din      = {c3, c2, c1, c0};
        tick();
    endtask

    task automatic drop();
        in_valid = 1'b0;
        din      = '0;
        tick();
    endtask

    // Handshake the held result, then let REARM see in_valid low
    task automatic accept();
        res_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        check("accept_res_valid", 64'(if0.res_valid), 64'd0);
        res_ready = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] pk(input logic [15:0] a3, input logic [15:0] a2, input logic [15:0] a1, input logic [15:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] ix12(input logic [11:0] a3, input logic [11:0] a2, input logic [11:0] a1, input logic [11:0] a0);
        return 64'({a3, a2, a1, a0});
    endfunction

    function automatic logic [63:0] ix3(input logic [2:0] a3, input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] a0);
        return 64'({a3, a2, a1, a0});
    endfunction

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_res_valid", 64'(if0.res_valid), 64'd0);
        check("rst_busy",      64'(if0.busy),      64'd0);
        check("rst_peak",      if0.peak,           64'd0);
        check("rst_idx",       64'(if0.peak_idx),  64'd0);
        check("rst_ovf",       64'(if0.ovf),       64'd0);
        check("rst_trunc",     64'(if0.trunc),     64'd0);
        check("rst_res_valid1", 64'(if1.res_valid), 64'd0);
        rst = 1'b0;
        tick();
        check("rearm_busy", 64'(if0.busy), 64'd0);

        // Burst 1: ch0 basic, ch1 saturating abs, ch2 threshold tie, ch3 all negative
        beat(16'd5,   16'd10,     16'd30000,      -16'sd1);
        check("acq_busy", 64'(if0.busy), 64'd1);
        beat(16'd100, 16'h8000,   -16'sd30000,    -16'sd5);
        beat(-16'sd3, 16'd200,    16'd7,          -16'sd100);
        beat(16'd100, 16'd0,      16'd30000,      -16'sd2);
        check("last_beat_no_valid", 64'(if0.res_valid), 64'd0);
        drop();
        check("b1_res_valid", 64'(if0.res_valid), 64'd1);
        check("b1_busy_hold", 64'(if0.busy),      64'd1);
        check("b1_peak0",  if0.peak,              pk(16'd0, 16'd30000, 16'd200, 16'd100));
        check("b1_idx0",   64'(if0.peak_idx),     ix12(12'd0, 12'd0, 12'd2, 12'd1));
        check("b1_ovf0",   64'(if0.ovf),          64'd0);
        check("b1_trunc0", 64'(if0.trunc),        64'd0);
        check("b1_peak1",  if1.peak,              pk(16'd100, 16'd30000, 16'd32767, 16'd100));
        check("b1_idx1",   64'(if1.peak_idx),     ix12(12'd2, 12'd0, 12'd1, 12'd1));
        check("b1_ovf1",   64'(if1.ovf),          64'b0010);
        check("b1_idx2",   64'(if2.peak_idx),     ix3(3'd0, 3'd0, 3'd2, 3'd1));

        // Hold with res_ready low for 10 cycles while another burst runs
        for (int k = 0; k < 10; k++) begin
            beat(16'd1000, 16'd1000, 16'd1000, 16'd32000);
            check("hold_valid", 64'(if0.res_valid), 64'd1);
            check("hold_peak",  if0.peak, pk(16'd0, 16'd30000, 16'd200, 16'd100));
        end
        check("hold_idx", 64'(if0.peak_idx), ix12(12'd0, 12'd0, 12'd2, 12'd1));
        check("hold_ovf", 64'(if0.ovf), 64'd0);
        // Handshake while the burst is still in progress; its tail must be ignored too
        res_ready = 1'b1;
        beat(16'd1000, 16'd1000, 16'd1000, 16'd32000);
        check("hs_res_valid", 64'(if0.res_valid), 64'd0);
        check("hs_busy",      64'(if0.busy),      64'd0);
        res_ready = 1'b0;
        beat(16'd1000, 16'd1000, 16'd1000, 16'd32000);
        beat(16'd1000, 16'd1000, 16'd1000, 16'd32000);
        drop();
        drop();
        check("ignored_valid", 64'(if0.res_valid), 64'd0);
        check("ignored_peak",  if0.peak, pk(16'd0, 16'd30000, 16'd200, 16'd100));

        // Fresh one-beat burst
        beat(16'd7, -16'sd2, 16'd0, 16'd31000);
        drop();
        check("one_valid", 64'(if0.res_valid), 64'd1);
        check("one_peak0", if0.peak,           pk(16'd31000, 16'd0, 16'd0, 16'd7));
        check("one_idx0",  64'(if0.peak_idx),  64'd0);
        check("one_ovf0",  64'(if0.ovf),       64'b1000);
        check("one_peak1", if1.peak,           pk(16'd31000, 16'd0, 16'd2, 16'd7));
        check("one_idx1",  64'(if1.peak_idx),  64'd0);
        accept();

        // Ten-beat burst, maximum at beat 9
        for (int k = 0; k < 10; k++) begin
            beat(16'(k * 10), 16'd0, 16'd0, 16'd0);
        end
        drop();
        check("tr_valid2", 64'(if2.res_valid), 64'd1);
        check("tr_peak2",  if2.peak,           pk(16'd0, 16'd0, 16'd0, 16'd90));
        check("tr_idx2",   64'(if2.peak_idx),  ix3(3'd0, 3'd0, 3'd0, 3'd7));
        check("tr_trunc2", 64'(if2.trunc),     64'd1);
        check("tr_idx0",   64'(if0.peak_idx),  ix12(12'd0, 12'd0, 12'd0, 12'd9));
        check("tr_trunc0", 64'(if0.trunc),     64'd0);
        accept();

        // Reset during beat 3 of 6 with in_valid held high
        beat(16'd500, 16'd0, 16'd0, 16'd0);
        beat(16'd600, 16'd0, 16'd0, 16'd0);
        beat(16'd700, 16'd0, 16'd0, 16'd0);
        rst = 1'b1;
        beat(16'd800, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        check("mid_rst_valid", 64'(if0.res_valid), 64'd0);
        check("mid_rst_busy",  64'(if0.busy),      64'd0);
        check("mid_rst_peak",  if0.peak,           64'd0);
        beat(16'd900, 16'd0, 16'd0, 16'd0);
        beat(16'd950, 16'd0, 16'd0, 16'd0);
        drop();
        drop();
        check("after_rst_valid", 64'(if0.res_valid), 64'd0);
        check("after_rst_busy",  64'(if0.busy),      64'd0);
        beat(16'd3, 16'd9, 16'd0, 16'd0);
        beat(16'd8, 16'd1, 16'd0, 16'd0);
        beat(16'd2, 16'd1, 16'd0, 16'd0);
        drop();
        check("post_rst_valid", 64'(if0.res_valid), 64'd1);
        check("post_rst_peak",  if0.peak,           pk(16'd0, 16'd0, 16'd9, 16'd8));
        check("post_rst_idx",   64'(if0.peak_idx),  ix12(12'd0, 12'd0, 12'd0, 12'd1));
        accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
